// File: rtl/median_pkg.sv
// Types shared across the median-filter pipeline: the RGB pixel format, the
// padder FSM states and the window-to-border helpers.
package median_pkg;

    localparam int DATA_WIDTH = 8;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] red;
        logic [DATA_WIDTH-1:0] green;
        logic [DATA_WIDTH-1:0] blue;
    } pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TOP    = 3'd1,
        ST_LEFT   = 3'd2,
        ST_BODY   = 3'd3,
        ST_RIGHT  = 3'd4,
        ST_BOTTOM = 3'd5,
        ST_DONE   = 3'd6
    } pad_state_t;

    function automatic int pad_of(input int window_size);
        return window_size / 2;
    endfunction

    function automatic pixel_t fill_pixel(input logic [DATA_WIDTH-1:0] value);
        return {value, value, value};
    endfunction

endpackage

// File: rtl/pixel_pad_streamer_if.sv
// Pixel handshake and frame-control bundle between an upstream image source,
// the padder and the median filter.
interface pixel_pad_streamer_if;
    import median_pkg::*;

    logic        start;
    logic        hold;
    pixel_t      in_pixel;
    logic        in_valid;
    logic        in_ready;
    pixel_t      new_pixel;
    logic        more_pixels;
    logic [31:0] max_windows;
    logic        busy;
    logic        done;

    modport slave (
        input  start, hold, in_pixel, in_valid,
        output in_ready, new_pixel, more_pixels, max_windows, busy, done
    );

    modport master (
        output start, hold, in_pixel, in_valid,
        input  in_ready, new_pixel, more_pixels, max_windows, busy, done
    );

endinterface

// File: rtl/pixel_pad_streamer.sv
// Wraps an unpadded raster in PAD rows/columns of PAD_VALUE and streams the
// padded frame to the median filter, one registered pixel per cycle at most.
module pixel_pad_streamer
    import median_pkg::*;
#(
    parameter int                    WINDOW_SIZE = 3,
    parameter int                    IMG_WIDTH   = 316,
    parameter int                    IMG_HEIGHT  = 303,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = 8'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_pad_streamer_if.slave  bus
);

    localparam int PAD   = pad_of(WINDOW_SIZE);
    localparam int PW    = IMG_WIDTH + 2 * PAD;
    localparam int PH    = IMG_HEIGHT + 2 * PAD;
    localparam int COL_W = (PW > 1) ? $clog2(PW) : 1;
    localparam int ROW_W = $clog2(PH + 1);

    // Terminal counter values; the PAD-1 ones are never reached when PAD=0.
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(PW - 1);
    localparam logic [COL_W-1:0] LEFT_LAST = COL_W'(PAD - 1);
    localparam logic [COL_W-1:0] BODY_LAST = COL_W'(PAD + IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] TOP_LAST  = ROW_W'(PAD - 1);
    localparam logic [ROW_W-1:0] IMG_LAST  = ROW_W'(PAD + IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(PH - 1);
    localparam bit               HAS_PAD   = (PAD > 0);
    localparam pixel_t           BORDER    = fill_pixel(PAD_VALUE);

    pad_state_t        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    pixel_t            pixel_q, pixel_d;
    logic              more_q, more_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              emit_s;
    logic              border_s;
    pad_state_t        after_row_s;

    // Emission decision, counter advance and next-state decode for one cycle.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        pixel_d  = pixel_q;
        more_d   = 1'b0;
        emit_s   = 1'b0;
        border_s = 1'b0;

        // Zero-length border states are skipped when the window has no PAD.
        if (row_q != IMG_LAST) begin
            after_row_s = HAS_PAD ? ST_LEFT : ST_BODY;
        end else begin
            after_row_s = HAS_PAD ? ST_BOTTOM : ST_DONE;
        end

        case (state_q)
            ST_TOP, ST_LEFT, ST_RIGHT, ST_BOTTOM: begin
                emit_s   = !bus.hold;
                border_s = 1'b1;
            end
            ST_BODY: begin
                emit_s   = bus.in_valid && !bus.hold;
                border_s = 1'b0;
            end
            default: begin
                emit_s   = 1'b0;
                border_s = 1'b0;
            end
        endcase

        if (emit_s) begin
            more_d  = 1'b1;
            pixel_d = border_s ? BORDER : bus.in_pixel;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else begin
            more_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                col_d = '0;
                row_d = '0;
                if (bus.start) begin
                    state_d = HAS_PAD ? ST_TOP : ST_BODY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TOP: begin
                if (emit_s && (col_q == COL_LAST) && (row_q == TOP_LAST)) begin
                    state_d = ST_LEFT;
                end else begin
                    state_d = ST_TOP;
                end
            end
            ST_LEFT: begin
                if (emit_s && (col_q == LEFT_LAST)) begin
                    state_d = ST_BODY;
                end else begin
                    state_d = ST_LEFT;
                end
            end
            ST_BODY: begin
                if (emit_s && (col_q == BODY_LAST)) begin
                    state_d = HAS_PAD ? ST_RIGHT : after_row_s;
                end else begin
                    state_d = ST_BODY;
                end
            end
            ST_RIGHT: begin
                if (emit_s && (col_q == COL_LAST)) begin
                    state_d = after_row_s;
                end else begin
                    state_d = ST_RIGHT;
                end
            end
            ST_BOTTOM: begin
                if (emit_s && (col_q == COL_LAST) && (row_q == ROW_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BOTTOM;
                end
            end
            ST_DONE: begin
                col_d   = '0;
                row_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                col_d   = '0;
                row_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d inside {ST_TOP, ST_LEFT, ST_BODY, ST_RIGHT, ST_BOTTOM});
        done_d = (state_q == ST_DONE);
    end

    // State, counters and registered outputs; reset aborts any frame at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pixel_q <= '0;
            more_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pixel_q <= pixel_d;
            more_q  <= more_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.in_ready    = (state_q == ST_BODY) && !bus.hold;
    assign bus.new_pixel   = pixel_q;
    assign bus.more_pixels = more_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.max_windows = 32'(IMG_WIDTH * IMG_HEIGHT);

endmodule
